// File: rtl/aia_src_cond_pkg.sv
// Shared constants and the per-source conditioning state type for the AIA
// wired-source conditioner.
package aia_src_pkg;

  localparam int NR_SOURCES_DEF  = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CNT_W_DEF  = 4;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } src_state_e;

endpackage

// File: rtl/aia_src_cond_if.sv
// Bundle of wired-source request lines and their conditioned results. The
// top uses a one-bit instance per source to feed each aia_src_filt.
interface aia_src_cond_if
  import aia_src_pkg::*;
#(
  parameter int N  = NR_SOURCES_DEF,
  parameter int FW = FILT_CNT_W_DEF
);

  logic [N-1:0]  src_async;
  logic [FW-1:0] filt_thresh;
  logic [N-1:0]  irq_sources;
  logic [N-1:0]  src_changed;

  modport master (
    output src_async,
    output filt_thresh,
    input  irq_sources,
    input  src_changed
  );

  modport slave (
    input  src_async,
    input  filt_thresh,
    output irq_sources,
    output src_changed
  );

endinterface

// File: rtl/aia_src_filt.sv
// One wired source: synchronizer chain, then either a deglitch counter/FSM
// (AIA_SRC_DEGLITCH_EN defined) or a single output register.
module aia_src_filt
  import aia_src_pkg::*;
#(
  parameter int SyncStages = SYNC_STAGES_DEF,
  parameter int FiltCntW   = FILT_CNT_W_DEF
) (
  input logic           i_clk,
  input logic           ni_rst,
  aia_src_cond_if.slave bus
);

  logic [SyncStages-1:0] sync_p;
  logic                  s;
  logic                  irq_q, irq_d;
  logic                  chg_q, chg_d;

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SyncStages-2:0], bus.src_async[0]};
    end
  end

  assign s = sync_p[SyncStages-1];

`ifdef AIA_SRC_DEGLITCH_EN
  src_state_e          state;
  logic [FiltCntW-1:0] cnt_q, cnt_d;

  // The FSM state is the mismatch between the synchronized level and the
  // committed output, so a new level starts counting on the very next edge.
  always_comb begin
    state = (s != irq_q) ? COUNTING : STABLE;
    cnt_d = '0;
    irq_d = irq_q;
    chg_d = 1'b0;
    unique case (state)
      STABLE: begin
        cnt_d = '0;
      end
      COUNTING: begin
        if (cnt_q >= bus.filt_thresh) begin
          irq_d = s;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + FiltCntW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
      chg_q <= chg_d;
    end
  end
`else
  logic unused_thresh;

  assign unused_thresh = ^bus.filt_thresh;

  always_comb begin
    irq_d = s;
    chg_d = s ^ irq_q;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      irq_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      chg_q <= chg_d;
    end
  end
`endif

  assign bus.irq_sources[0] = irq_q;
  assign bus.src_changed[0] = chg_q;

endmodule

// File: rtl/aia_src_cond.sv
// Conditions NrSources raw interrupt wires for the APLIC. Deglitch filtering
// is present only when AIA_SRC_DEGLITCH_EN is defined.
module aia_src_cond
  import aia_src_pkg::*;
#(
  parameter int NrSources  = NR_SOURCES_DEF,
  parameter int SyncStages = SYNC_STAGES_DEF,
  parameter int FiltCntW   = FILT_CNT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 ni_rst,
  input  logic [NrSources-1:0] i_src_async,
  input  logic [FiltCntW-1:0]  i_filt_thresh,
  output logic [NrSources-1:0] o_irq_sources,
  output logic [NrSources-1:0] o_src_changed
);

  for (genvar g = 0; g < NrSources; g++) begin : g_src
    aia_src_cond_if #(.N(1), .FW(FiltCntW)) src_bus ();

    assign src_bus.src_async[0] = i_src_async[g];
    assign src_bus.filt_thresh  = i_filt_thresh;
    assign o_irq_sources[g]     = src_bus.irq_sources[0];
    assign o_src_changed[g]     = src_bus.src_changed[0];

    aia_src_filt #(
      .SyncStages(SyncStages),
      .FiltCntW  (FiltCntW)
    ) u_filt (
      .i_clk (i_clk),
      .ni_rst(ni_rst),
      .bus   (src_bus.slave)
    );
  end

endmodule

// File: tb/tb_aia_src_cond.sv
// Scoreboard bench for aia_src_cond; expectations follow whichever build
// (AIA_SRC_DEGLITCH_EN defined or not) is compiled.
module tb_aia_src_cond;
  import aia_src_pkg::*;

  localparam int N  = 32;
  localparam int S  = 2;
  localparam int FW = 4;

  typedef struct {
    int          cyc;
    logic [N-1:0] irq;
    logic [N-1:0] chg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  aia_src_cond_if #(.N(N), .FW(FW)) bus ();

  aia_src_cond #(
    .NrSources (N),
    .SyncStages(S),
    .FiltCntW  (FW)
  ) dut (
    .i_clk        (clk),
    .ni_rst       (rst_n),
    .i_src_async  (bus.src_async),
    .i_filt_thresh(bus.filt_thresh),
    .o_irq_sources(bus.irq_sources),
    .o_src_changed(bus.src_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edges from input change to committed output, counting the sampling edge.
  function automatic int lat(int t);
`ifdef AIA_SRC_DEGLITCH_EN
    return S + t + 1;
`else
    return S + 1;
`endif
  endfunction

  function automatic logic [N-1:0] bitv(int b, logic v);
    logic [N-1:0] r;
    r    = '0;
    r[b] = v;
    return r;
  endfunction

  task automatic push(int c, logic [N-1:0] irq, logic [N-1:0] chg);
    exp_t e;
    e.cyc = c;
    e.irq = irq;
    e.chg = chg;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.src_async   = '1;
    bus.filt_thresh = 4'd3;
    rst_n           = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.irq_sources !== '0 || bus.src_changed !== '0) begin
        bad++;
        $display("FAIL reset_hold irq=%h chg=%h want 0 0", bus.irq_sources, bus.src_changed);
      end
    end
    bus.src_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (bus.irq_sources !== '0 || bus.src_changed !== '0) begin
      bad++;
      $display("FAIL reset_release irq=%h chg=%h want 0 0", bus.irq_sources, bus.src_changed);
    end
  endtask

  task automatic test_rise();
    int   k0, k1, kend, l;
    exp_t it;
    bus.filt_thresh = 4'd3;
    l    = lat(3);
    k0   = cyc;
    k1   = k0 + 10;
    kend = k1 + l + 2;
    for (int c = k0 + 1; c <= kend; c++)
      push(c, bitv(0, (c >= k0 + l) && (c < k1 + l)), bitv(0, (c == k0 + l) || (c == k1 + l)));
    bus.src_async[0] = 1'b1;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL rise c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == k1) bus.src_async[0] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    int   k0, kend, l;
    exp_t it;
    bus.filt_thresh = 4'd3;
    l    = lat(3);
    k0   = cyc;
    kend = k0 + 14;
    for (int c = k0 + 1; c <= kend; c++) begin
`ifdef AIA_SRC_DEGLITCH_EN
      push(c, '0, '0);
`else
      push(c, bitv(5, (c >= k0 + l) && (c < k0 + 2 + l)),
           bitv(5, (c == k0 + l) || (c == k0 + 2 + l)));
`endif
    end
    bus.src_async[5] = 1'b1;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL glitch c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == k0 + 2) bus.src_async[5] = 1'b0;
    end
  endtask

  task automatic test_toggle();
    int   k0, kend, l, n;
    logic p;
    exp_t it;
    bus.filt_thresh = 4'd0;
    l    = lat(0);
    k0   = cyc;
    kend = k0 + 12 + l + 2;
    for (int c = k0 + 1; c <= kend; c++) begin
      n = 0;
      p = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (c >= k0 + 4 * j + l) n++;
        if (c == k0 + 4 * j + l) p = 1'b1;
      end
      push(c, bitv(7, n[0]), bitv(7, p));
    end
    bus.src_async[7] = 1'b1;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL toggle c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == k0 + 4 || cyc == k0 + 8 || cyc == k0 + 12)
        bus.src_async[7] = ~bus.src_async[7];
    end
  endtask

`ifdef AIA_SRC_DEGLITCH_EN
  task automatic test_thresh_drop();
    int   k0, kend;
    exp_t it;
    bus.filt_thresh = 4'd15;
    k0   = cyc;
    kend = k0 + 22;
    // Count reaches 8 by edge k0+10; lowering to 2 commits on edge k0+11.
    // The fall then needs the full lat(2) = 5 edges, proving cnt was cleared.
    for (int c = k0 + 1; c <= kend; c++)
      push(c, bitv(3, (c >= k0 + 11) && (c < k0 + 19)),
           bitv(3, (c == k0 + 11) || (c == k0 + 19)));
    bus.src_async[3] = 1'b1;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL thresh_drop c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == k0 + 10) bus.filt_thresh = 4'd2;
      if (cyc == k0 + 14) bus.src_async[3] = 1'b0;
    end
  endtask
`else
  task automatic test_passthru();
    int   k0, kend, l;
    exp_t it;
    bus.filt_thresh = 4'd7;
    l    = lat(7);
    k0   = cyc;
    kend = k0 + 8;
    for (int c = k0 + 1; c <= kend; c++)
      push(c, bitv(2, c == k0 + l), bitv(2, (c == k0 + l) || (c == k0 + l + 1)));
    bus.src_async[2] = 1'b1;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL passthru c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == k0 + 1) bus.src_async[2] = 1'b0;
    end
  endtask
`endif

  task automatic test_reset_mid();
    int           k0, klow, krel, kend, l;
    logic [N-1:0] mask;
    exp_t         it;
    bus.filt_thresh = 4'd3;
    mask = '0;
    mask[0] = 1'b1;
    mask[1] = 1'b1;
    mask[31] = 1'b1;
    l    = lat(3);
    k0   = cyc;
    klow = k0 + l - 2;
    krel = klow + 2;
    kend = krel + l + 2;
    for (int c = k0 + 1; c <= kend; c++)
      push(c, (c >= krel + l) ? mask : '0, (c == krel + l) ? mask : '0);
    bus.src_async = mask;
    while (cyc < kend) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        total++;
        if (it.cyc != cyc || bus.irq_sources !== it.irq || bus.src_changed !== it.chg) begin
          bad++;
          $display("FAIL reset_mid c=%0d irq=%h chg=%h want %h %h", cyc, bus.irq_sources,
                   bus.src_changed, it.irq, it.chg);
        end
      end
      if (cyc == klow) rst_n = 1'b0;
      if (cyc == krel) rst_n = 1'b1;
    end
    // Outputs are high now; reset must clear them without waiting for a clock.
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.irq_sources !== '0 || bus.src_changed !== '0) begin
      bad++;
      $display("FAIL reset_async irq=%h chg=%h want 0 0", bus.irq_sources, bus.src_changed);
    end
    bus.src_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (l + 3) @(negedge clk);
    total++;
    if (bus.irq_sources !== '0 || bus.src_changed !== '0) begin
      bad++;
      $display("FAIL reset_quiet irq=%h chg=%h want 0 0", bus.irq_sources, bus.src_changed);
    end
  endtask

  initial begin
    bus.src_async   = '0;
    bus.filt_thresh = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_toggle();
`ifdef AIA_SRC_DEGLITCH_EN
    test_thresh_drop();
`else
    test_passthru();
`endif
    test_reset_mid();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
